// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - micro-sequencer that fetches from program memory, drives the 8-bit ALU
// and emits output bytes over a valid/ready handshake.
module alu_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk_SEQ,
  input  logic            rstn_SEQ,
  input  logic            start,
  output logic            busy,
  output logic            halted,
  output logic [PC_W-1:0] pm_addr,
  input  logic [7:0]      pm_data,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [2:0]      alu_f,
  output logic            alu_write_cz,
  input  logic [7:0]      alu_c,
  input  logic            alu_cf,
  input  logic            alu_zf,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    OPERAND,
    EXEC,
    OUT_WAIT,
    HALTED
  } seqState_t;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_SYS = 2'b11;

  seqState_t       state, stateNext;
  logic [PC_W-1:0] pc, pcNext, pcInc;
  logic [7:0]      regA, regANext;
  logic [7:0]      regB, regBNext;
  logic [7:0]      ir, irNext;
  logic [7:0]      outData, outDataNext;
  logic            outValid, outValidNext;
  logic [2:0]      aluF;
  logic            aluWcz;
  logic            jumpTaken;
  logic            unusedIrBit;

  // ir[0] carries no meaning in any encoding
  assign unusedIrBit = ir[0];

  assign pcInc = pc + PC_W'(1);

  always_comb begin
    jumpTaken = 1'b0;
    case (ir[5:4])
      2'b00:   jumpTaken = 1'b1;
      2'b01:   jumpTaken = alu_cf;
      2'b10:   jumpTaken = alu_zf;
      default: jumpTaken = ~alu_zf;
    endcase
  end

  always_ff @(posedge clk_SEQ or negedge rstn_SEQ) begin
    if (!rstn_SEQ) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext    = state;
    pcNext       = pc;
    regANext     = regA;
    regBNext     = regB;
    irNext       = ir;
    outDataNext  = outData;
    outValidNext = outValid;
    aluF         = 3'b000;
    aluWcz       = 1'b0;

    case (state)
      IDLE, HALTED: begin
        if (start) begin
          stateNext = FETCH;
          pcNext    = '0;
        end
      end

      FETCH: stateNext = DECODE;

      // pm_data here is the opcode byte addressed during FETCH
      DECODE: begin
        irNext = pm_data;
        pcNext = pcInc;
        case (pm_data[7:6])
          OP_ALU:         stateNext = EXEC;
          OP_LDI, OP_JMP: stateNext = OPERAND;
          default: begin
            if (pm_data[5]) begin
              stateNext = HALTED;
            end else begin
              stateNext    = OUT_WAIT;
              outDataNext  = pm_data[4] ? regB : regA;
              outValidNext = 1'b1;
            end
          end
        endcase
      end

      OPERAND: stateNext = EXEC;

      // For LDI/JMP pm_data now holds the operand byte fetched during OPERAND
      EXEC: begin
        stateNext = FETCH;
        case (ir[7:6])
          OP_ALU: begin
            aluF   = ir[5:3];
            aluWcz = ir[1];
            if (ir[2]) regBNext = alu_c;
            else       regANext = alu_c;
          end
          OP_LDI: begin
            if (ir[5]) regBNext = pm_data;
            else       regANext = pm_data;
            pcNext = pcInc;
          end
          OP_JMP: begin
            pcNext = jumpTaken ? pm_data[PC_W-1:0] : pcInc;
          end
          OP_SYS: begin
            stateNext = FETCH;
          end
          default: begin
            stateNext = FETCH;
          end
        endcase
      end

      OUT_WAIT: begin
        if (outValid && out_ready) begin
          outValidNext = 1'b0;
          stateNext    = FETCH;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_SEQ or negedge rstn_SEQ) begin
    if (!rstn_SEQ) begin
      pc       <= '0;
      regA     <= 8'h00;
      regB     <= 8'h00;
      ir       <= 8'h00;
      outData  <= 8'h00;
      outValid <= 1'b0;
    end else begin
      pc       <= pcNext;
      regA     <= regANext;
      regB     <= regBNext;
      ir       <= irNext;
      outData  <= outDataNext;
      outValid <= outValidNext;
    end
  end

  assign busy         = (state != IDLE) && (state != HALTED);
  assign halted       = (state == HALTED);
  assign pm_addr      = pc;
  assign alu_a        = regA;
  assign alu_b        = regB;
  assign alu_f        = aluF;
  assign alu_write_cz = aluWcz;
  assign out_data     = outData;
  assign out_valid    = outValid;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed bench for alu_sequencer with a program memory and ALU model
// around it, plus a PC_W=4 instance for the address wrap.
module tb_alu_sequencer;

  logic       clk;
  logic       rstn;
  logic       start;
  logic       busy, halted;
  logic [7:0] pmAddr;
  logic [7:0] pmData;
  logic [7:0] aluA, aluB, aluC;
  logic [2:0] aluF;
  logic       aluWcz;
  logic       aluCf = 1'b0;
  logic       aluZf = 1'b0;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;
  logic [8:0] aluRes9;

  logic       start4;
  logic       busy4, halted4;
  logic [3:0] pmAddr4;
  logic [7:0] pmData4;
  logic [7:0] aluA4, aluB4;
  logic [2:0] aluF4;
  logic       aluWcz4;
  logic [7:0] outData4;
  logic       outValid4;

  logic [7:0] mem  [0:255];
  logic [7:0] mem4 [0:15];

  int nCompared   = 0;
  int nMismatched = 0;
  int wczCount    = 0;
  int wczBase;

  alu_sequencer #(.PC_W(8)) dut (
    .clk_SEQ(clk), .rstn_SEQ(rstn), .start(start),
    .busy(busy), .halted(halted),
    .pm_addr(pmAddr), .pm_data(pmData),
    .alu_a(aluA), .alu_b(aluB), .alu_f(aluF), .alu_write_cz(aluWcz),
    .alu_c(aluC), .alu_cf(aluCf), .alu_zf(aluZf),
    .out_data(outData), .out_valid(outValid), .out_ready(outReady)
  );

  alu_sequencer #(.PC_W(4)) dut4 (
    .clk_SEQ(clk), .rstn_SEQ(rstn), .start(start4),
    .busy(busy4), .halted(halted4),
    .pm_addr(pmAddr4), .pm_data(pmData4),
    .alu_a(aluA4), .alu_b(aluB4), .alu_f(aluF4), .alu_write_cz(aluWcz4),
    .alu_c(aluA4), .alu_cf(1'b0), .alu_zf(1'b0),
    .out_data(outData4), .out_valid(outValid4), .out_ready(1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) pmData  <= mem[pmAddr];
  always @(posedge clk) pmData4 <= mem4[pmAddr4];

  // Reference ALU: bit 8 is carry for add/increment and borrow for subtract
  always_comb begin
    aluRes9 = 9'h000;
    case (aluF)
      3'b000:  aluRes9 = {1'b0, aluA};
      3'b001:  aluRes9 = {1'b0, aluB};
      3'b010:  aluRes9 = {1'b0, aluA} + 9'd1;
      3'b011:  aluRes9 = {1'b0, aluB} + 9'd1;
      3'b100:  aluRes9 = {1'b0, aluA} + {1'b0, aluB};
      3'b101:  aluRes9 = {1'b0, aluA} - {1'b0, aluB};
      3'b110:  aluRes9 = {1'b0, aluA & aluB};
      default: aluRes9 = {1'b0, aluA | aluB};
    endcase
  end
  assign aluC = aluRes9[7:0];

  always @(posedge clk) begin
    if (aluWcz) begin
      aluCf <= aluRes9[8];
      aluZf <= (aluRes9[7:0] == 8'h00);
    end
  end

  always @(negedge clk) if (aluWcz) wczCount++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic doReset();
    rstn = 1'b0;
    ticks(2);
    rstn = 1'b1;
    tick();
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // Leaves the machine in its first FETCH cycle
  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic loadJumpTest(input logic [7:0] bVal, input logic [7:0] aluOp);
    clearMem();
    mem[0] = 8'h40; mem[1] = 8'h05;
    mem[2] = 8'h60; mem[3] = bVal;
    mem[4] = aluOp;
    mem[5] = 8'hA0; mem[6] = 8'h0A;
    mem[7] = 8'hE0;
    mem[10] = 8'hE0;
  endtask

  task automatic loadOutTest();
    clearMem();
    mem[0] = 8'h40; mem[1] = 8'h3C;
    mem[2] = 8'hC0;
    mem[3] = 8'hE0;
  endtask

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    start4 = 1'b0;
    outReady = 1'b0;
    clearMem();
    for (int i = 0; i < 16; i++) mem4[i] = 8'h00;
    doReset();

    chk("reset_busy", busy, 1'b0);
    chk("reset_halted", halted, 1'b0);
    chk("reset_pc", pmAddr, 8'h00);
    chk("reset_regA", aluA, 8'h00);
    chk("reset_regB", aluB, 8'h00);
    chk("reset_out_valid", outValid, 1'b0);
    chk("reset_out_data", outData, 8'h00);
    chk("reset_alu_f", aluF, 3'b000);
    chk("reset_wcz", aluWcz, 1'b0);

    // Add with carry: FF + 02
    clearMem();
    mem[0] = 8'h40; mem[1] = 8'hFF;
    mem[2] = 8'h60; mem[3] = 8'h02;
    mem[4] = 8'h22;
    mem[5] = 8'hE0;
    wczBase = wczCount;
    pulseStart();
    chk("add_busy_fetch", busy, 1'b1);
    ticks(12);
    chk("add_not_halted_12", halted, 1'b0);
    tick();
    chk("add_halted_13", halted, 1'b1);
    chk("add_busy_halted", busy, 1'b0);
    chk("add_regA", aluA, 8'h01);
    chk("add_regB", aluB, 8'h02);
    chk("add_cf", aluCf, 1'b1);
    chk("add_zf", aluZf, 1'b0);
    chk("add_wcz_pulses", wczCount - wczBase, 1);

    // JZ taken: 5-5 sets ZF
    doReset();
    loadJumpTest(8'h05, 8'h2A);
    pulseStart();
    ticks(15);
    chk("jz_taken_pc", pmAddr, 8'h0A);
    ticks(2);
    chk("jz_taken_halted", halted, 1'b1);

    // JZ not taken: 5-4 clears ZF
    doReset();
    loadJumpTest(8'h04, 8'h2A);
    pulseStart();
    ticks(15);
    chk("jz_fall_pc", pmAddr, 8'h07);
    ticks(2);
    chk("jz_fall_halted", halted, 1'b1);
    chk("jz_fall_regA", aluA, 8'h01);

    // Flags not written: 5-5 with wcz=0, ZF stays 0
    doReset();
    loadJumpTest(8'h05, 8'h28);
    wczBase = wczCount;
    pulseStart();
    ticks(15);
    chk("nowcz_pc", pmAddr, 8'h07);
    chk("nowcz_regA", aluA, 8'h00);
    chk("nowcz_strobes", wczCount - wczBase, 0);

    // Output stall: ready low 5 cycles
    doReset();
    loadOutTest();
    outReady = 1'b0;
    pulseStart();
    ticks(5);
    chk("out_valid_decode", outValid, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("out_valid_stall", outValid, 1'b1);
      chk("out_data_stall", outData, 8'h3C);
      tick();
    end
    outReady = 1'b1;
    chk("out_valid_hs", outValid, 1'b1);
    chk("out_data_hs", outData, 8'h3C);
    tick();
    outReady = 1'b0;
    chk("out_valid_drop", outValid, 1'b0);
    chk("out_next_fetch_pc", pmAddr, 8'h03);
    chk("out_busy_fetch", busy, 1'b1);
    ticks(2);
    chk("out_halted", halted, 1'b1);

    // Asynchronous reset while in OUT_WAIT
    doReset();
    loadOutTest();
    outReady = 1'b0;
    pulseStart();
    ticks(8);
    chk("rst_pre_valid", outValid, 1'b1);
    chk("rst_pre_regA", aluA, 8'h3C);
    rstn = 1'b0;
    #1;
    chk("rst_out_valid", outValid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pc", pmAddr, 8'h00);
    chk("rst_regA", aluA, 8'h00);
    chk("rst_regB", aluB, 8'h00);
    chk("rst_out_data", outData, 8'h00);
    tick();
    rstn = 1'b1;
    tick();

    // PC wrap with PC_W=4, mid-run start ignored
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("wrap_fetch0", pmAddr4, 4'h0);
    ticks(20);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("wrap_start_ignored", pmAddr4, 4'h7);
    chk("wrap_busy", busy4, 1'b1);
    ticks(24);
    chk("wrap_fetch15", pmAddr4, 4'hF);
    ticks(2);
    chk("wrap_exec15", pmAddr4, 4'h0);
    ticks(3);
    chk("wrap_exec0", pmAddr4, 4'h1);
    chk("wrap_busy_after", busy4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Micro-sequencer driving the 8-bit ALU from the controlling side. It fetches instructions from a synchronous program memory and holds the A and B working registers. It issues the ALU function code and the `write_cz` strobe, writes the ALU result back, branches on the ALU's registered carry and zero flags, and emits output bytes over a valid/ready handshake. It sits between program memory, the ALU and the output port in the CPU top level.

## Interface
- `PC_W`, default 8: program counter and program-memory address width.
- `clk_SEQ` in 1: clock; all state changes on the rising edge.
- `rstn_SEQ` in 1: asynchronous, active-low reset.
- `start` in 1: begin execution at address 0; honoured in IDLE and HALTED only.
- `busy` out 1: high in every state except IDLE and HALTED.
- `halted` out 1: high in HALTED.
- `pm_addr` out PC_W: equal to the PC at all times.
- `pm_data` in 8: program byte; `mem[pm_addr]` is valid one cycle after the address is presented.
- `alu_a`, `alu_b` out 8: always equal to regA and regB.
- `alu_f` out 3: ALU function code; 000 when not in EXEC of an ALU instruction.
- `alu_write_cz` out 1: flag-update strobe to the ALU.
- `alu_c` in 8: combinational ALU result.
- `alu_cf`, `alu_zf` in 1: flags held in ALU registers.
- `out_data` out 8: output byte.
- `out_valid` out 1: output byte valid.
- `out_ready` in 1: output consumer ready.

## Operation
- ALU function codes:
  - 000: A
  - 001: B
  - 010: A+1
  - 011: B+1
  - 100: A+B
  - 101: A−B
  - 110: A&B
  - 111: A|B
- The ALU updates CF and ZF on the clock edge where `alu_write_cz`=1.
- Instruction encoding:
  - `[7:6]=00` ALU op. `[5:3]` is f, `[2]` is the destination (0=A, 1=B), `[1]` is write_cz, `[0]` is ignored. One byte.
  - `[7:6]=01` LDI. `[5]` is the destination (0=A, 1=B); `[4:0]` is ignored. The second byte is the 8-bit immediate.
  - `[7:6]=10` JMP. `[5:4]` is the condition: 00 always, 01 CF=1, 10 ZF=1, 11 ZF=0. `[3:0]` is ignored. The second byte is the target, using its low PC_W bits.
  - `[7:6]=11` with `[5]=0` is OUT. `[4]` selects the source (0=A, 1=B). One byte.
  - `[7:6]=11` with `[5]=1` is HALT. One byte.
- State machine: IDLE, FETCH, DECODE, OPERAND, EXEC, OUT_WAIT, HALTED.
  - IDLE or HALTED: on `start`, set PC=0, clear `halted`, go to FETCH.
  - FETCH: the address is presented. Go to DECODE.
  - DECODE: IR←`pm_data`, PC←PC+1.
    - ALU op goes to EXEC.
    - LDI and JMP go to OPERAND.
    - OUT goes to OUT_WAIT, loading `out_data` from the selected register and setting `out_valid`=1.
    - HALT goes to HALTED.
  - OPERAND: wait one cycle for the operand read. Go to EXEC.
  - EXEC, ALU op:
    - Drive `alu_f`=IR[5:3] and `alu_write_cz`=IR[1].
    - Write `alu_c` to the destination at the end of the cycle.
    - Go to FETCH.
  - EXEC, LDI: write `pm_data` to the destination, PC←PC+1, go to FETCH.
  - EXEC, JMP: sample `alu_cf` and `alu_zf` this cycle.
    - Taken: PC←`pm_data`[PC_W-1:0].
    - Not taken: PC←PC+1.
    - Go to FETCH.
  - OUT_WAIT: hold `out_data` and `out_valid`. When `out_valid`&&`out_ready`, clear `out_valid` and go to FETCH.
- PC arithmetic wraps modulo 2^PC_W, including an operand fetched from the last address.
- `start` in any other state is ignored.

## Timing
- Reset values, asynchronous on `rstn_SEQ`=0:
  - state=IDLE, PC=0, regA=0, regB=0, IR=0.
  - `busy`=0, `halted`=0.
  - `out_valid`=0, `out_data`=0.
  - `alu_f`=000, `alu_write_cz`=0.
- Reset mid-instruction discards it; no partial writes survive.
- Instruction latency, counted from entering FETCH to the next FETCH:
  - ALU op: 3 cycles.
  - LDI and JMP: 4 cycles.
  - OUT: 3 + n cycles, where n is the number of wait cycles with `out_ready` low.
  - HALT: 2 cycles to HALTED.
- `start` sampled high in IDLE puts the machine in FETCH, with `busy`=1, on the next cycle.
- `alu_write_cz` is high for exactly one cycle per ALU op with IR[1]=1. A JMP immediately following sees the updated flags.
- `out_valid` rises in the cycle after DECODE and drops in the cycle after the handshake. `out_data` is stable while `out_valid`=1.

## Test plan
- **Add with carry.** Program: LDI A,FF; LDI B,02; ALU f=100 dest A wcz=1; HALT; `start` pulse. Required: regA=0x01, ALU CF=1, `halted`=1 exactly 13 cycles after FETCH is entered.
- **Conditional jumps.** Program: LDI A,05; LDI B,05; ALU f=101 wcz=1; JZ 0x0A. Required: PC=0x0A after EXEC. Repeat with B=04: PC falls through to the next sequential address.
- **Flags not written.** Same as the jump test with wcz=0 and ZF previously 0. Required: JZ not taken, and `alu_write_cz` never asserted.
- **Output stall.** Program: OUT A with A=0x3C; `out_ready` low for 5 cycles, then high. Required: `out_valid` held 6 cycles, `out_data`=0x3C throughout, next FETCH one cycle after the handshake.
- **Reset in OUT_WAIT.** Assert `rstn_SEQ` while in OUT_WAIT. Required: `out_valid`=0, `busy`=0, PC=0, regA=regB=0 immediately and asynchronously.
- **PC wrap.** With PC_W=4, run a program of 16 ALU NOP bytes (f=000, dest A, wcz=0). Required: `pm_addr` steps 15→0, and `start` asserted mid-run is ignored.
